// File: rtl/layer_sequencer_pkg.sv
// Shared types and defaults for the layer sequencer and its result collector.
// Default widths line up with the neuron array's dataWidth / ROM_bitwidth.
package layer_sequencer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_OUT_WIDTH  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLoadW,
        StLoadB,
        StFeed,
        StWait,
        StDrain
    } seq_state_e;

    // Neuron select fields carry 2*DATA_WIDTH+1 bits to match the neuron compare logic.
    function automatic int cfg_sel_w(input int data_width);
        return 2 * data_width + 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Stream-side bus of the layer sequencer: config load, inference input and result output.
// The slave modport is the sequencer; the master modport is the AXI-side adapter.
interface layer_sequencer_if
    import layer_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
);

    logic                  cfg_start;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [DATA_WIDTH-1:0] cfg_data;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_last;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/layer_sequencer_result_collector.sv
// Captures each neuron's activation on its outvalid while waiting, then serialises
// the buffered results onto the output stream in neuron order.
module layer_sequencer_result_collector #(
    parameter int NUM_NEURON = 16,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_clear,
    input  logic                             i_capture,
    input  logic                             i_drain,
    input  logic [NUM_NEURON-1:0]            i_nrn_outvalid,
    input  logic [NUM_NEURON*OUT_WIDTH-1:0]  i_nrn_out,
    input  logic                             i_out_ready,
    output logic                             o_out_valid,
    output logic [OUT_WIDTH-1:0]             o_out_data,
    output logic                             o_out_last,
    output logic                             o_mask_full,
    output logic                             o_drain_done
);

    localparam int CW = $clog2(NUM_NEURON) + 1;
    localparam int IW = CW - 1;

    logic [OUT_WIDTH-1:0]  r_buf [NUM_NEURON];
    logic [NUM_NEURON-1:0] r_mask;
    logic [CW-1:0]         r_idx;

    logic [IW-1:0]         w_idx;
    logic                  w_is_last;
    logic                  w_fire;

    assign w_idx     = r_idx[IW-1:0];
    assign w_is_last = (r_idx == CW'(NUM_NEURON - 1));
    assign w_fire    = i_drain && i_out_ready;

    assign o_out_valid  = i_drain;
    assign o_out_data   = i_drain ? r_buf[w_idx] : '0;
    assign o_out_last   = i_drain && w_is_last;
    assign o_mask_full  = &r_mask;
    assign o_drain_done = w_fire && w_is_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mask <= '0;
            r_idx  <= '0;
            for (int k = 0; k < NUM_NEURON; k++) begin
                r_buf[k] <= '0;
            end
        end else if (i_clear) begin
            // Uncaptured entries must read back as zero after a timeout.
            r_mask <= '0;
            r_idx  <= '0;
            for (int k = 0; k < NUM_NEURON; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            if (i_capture) begin
                for (int k = 0; k < NUM_NEURON; k++) begin
                    if (i_nrn_outvalid[k]) begin
                        r_buf[k]  <= i_nrn_out[k*OUT_WIDTH +: OUT_WIDTH];
                        r_mask[k] <= 1'b1;
                    end
                end
            end
            if (w_fire) begin
                r_idx <= w_is_last ? '0 : r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: loads weights and biases into the neuron array,
// broadcasts inference inputs, and hands the captured activations to the result collector.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int NUM_WEIGHT   = 128,
    parameter int NUM_NEURON   = 16,
    parameter int LAYER_NO     = 1,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    layer_sequencer_if.slave                 io_bus,
    output logic                             o_nrn_rst,
    output logic                             o_weight_valid,
    output logic [DATA_WIDTH-1:0]            o_weight_value,
    output logic [NUM_NEURON-1:0]            o_bias_valid,
    output logic [DATA_WIDTH-1:0]            o_bias_value,
    output logic [cfg_sel_w(DATA_WIDTH)-1:0] o_config_layer_num,
    output logic [cfg_sel_w(DATA_WIDTH)-1:0] o_config_neuron_num,
    output logic                             o_nrn_in_valid,
    output logic [DATA_WIDTH-1:0]            o_nrn_in,
    input  logic [NUM_NEURON-1:0]            i_nrn_outvalid,
    input  logic [NUM_NEURON*OUT_WIDTH-1:0]  i_nrn_out,
    output logic                             o_loaded,
    output logic                             o_busy,
    output logic                             o_err_timeout
);

    localparam int CFG_SEL_W = cfg_sel_w(DATA_WIDTH);
    localparam int WW        = $clog2(NUM_WEIGHT) + 1;
    localparam int NW        = $clog2(NUM_NEURON) + 1;
    localparam int TW        = $clog2(WAIT_TIMEOUT) + 1;

    localparam logic [WW-1:0] W_LAST = WW'(NUM_WEIGHT - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURON - 1);
    localparam logic [TW-1:0] T_LAST = TW'(WAIT_TIMEOUT - 1);

    seq_state_e             r_state;
    logic [WW-1:0]          r_wcnt;
    logic [NW-1:0]          r_ncnt;
    logic [TW-1:0]          r_timer;
    logic                   r_loaded;
    logic                   r_err;
    logic                   r_nrn_rst;
    logic                   r_weight_valid;
    logic [DATA_WIDTH-1:0]  r_weight_value;
    logic [NUM_NEURON-1:0]  r_bias_valid;
    logic [DATA_WIDTH-1:0]  r_bias_value;
    logic [CFG_SEL_W-1:0]   r_cfg_neuron_num;
    logic                   r_nrn_in_valid;
    logic [DATA_WIDTH-1:0]  r_nrn_in;

    logic                   w_cfg_fire;
    logic                   w_in_fire;
    logic                   w_clear;
    logic                   w_mask_full;
    logic                   w_drain_done;

    assign io_bus.cfg_ready = (r_state == StLoadW) || (r_state == StLoadB);
    assign io_bus.in_ready  = (r_state == StFeed);

    assign w_cfg_fire = io_bus.cfg_valid && io_bus.cfg_ready;
    assign w_in_fire  = io_bus.in_valid && io_bus.in_ready;
    assign w_clear    = w_in_fire && (r_wcnt == W_LAST);

    assign o_nrn_rst           = r_nrn_rst;
    assign o_weight_valid      = r_weight_valid;
    assign o_weight_value      = r_weight_value;
    assign o_bias_valid        = r_bias_valid;
    assign o_bias_value        = r_bias_value;
    assign o_config_layer_num  = CFG_SEL_W'(LAYER_NO);
    assign o_config_neuron_num = r_cfg_neuron_num;
    assign o_nrn_in_valid      = r_nrn_in_valid;
    assign o_nrn_in            = r_nrn_in;
    assign o_loaded            = r_loaded;
    assign o_busy              = (r_state != StIdle);
    assign o_err_timeout       = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= StIdle;
            r_wcnt           <= '0;
            r_ncnt           <= '0;
            r_timer          <= '0;
            r_loaded         <= 1'b0;
            r_err            <= 1'b0;
            r_nrn_rst        <= 1'b0;
            r_weight_valid   <= 1'b0;
            r_weight_value   <= '0;
            r_bias_valid     <= '0;
            r_bias_value     <= '0;
            r_cfg_neuron_num <= '0;
            r_nrn_in_valid   <= 1'b0;
            r_nrn_in         <= '0;
        end else begin
            r_nrn_rst      <= 1'b0;
            r_weight_valid <= 1'b0;
            r_bias_valid   <= '0;
            r_nrn_in_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.cfg_start) begin
                        r_state   <= StClr;
                        r_nrn_rst <= 1'b1;
                        r_err     <= 1'b0;
                    end else if (r_loaded && io_bus.in_valid) begin
                        r_state <= StFeed;
                        r_wcnt  <= '0;
                    end
                end
                StClr: begin
                    r_loaded         <= 1'b0;
                    r_wcnt           <= '0;
                    r_ncnt           <= '0;
                    r_cfg_neuron_num <= '0;
                    r_state          <= StLoadW;
                end
                StLoadW: begin
                    if (w_cfg_fire) begin
                        r_weight_valid   <= 1'b1;
                        r_weight_value   <= io_bus.cfg_data;
                        // Select moves with the first weight of each new neuron.
                        r_cfg_neuron_num <= CFG_SEL_W'(r_ncnt);
                        if (r_wcnt == W_LAST) begin
                            r_wcnt <= '0;
                            if (r_ncnt == N_LAST) begin
                                r_ncnt  <= '0;
                                r_state <= StLoadB;
                            end else begin
                                r_ncnt <= r_ncnt + 1'b1;
                            end
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                StLoadB: begin
                    r_cfg_neuron_num <= '1;
                    if (w_cfg_fire) begin
                        r_bias_valid <= NUM_NEURON'(1) << r_ncnt;
                        r_bias_value <= io_bus.cfg_data;
                        if (r_ncnt == N_LAST) begin
                            r_ncnt   <= '0;
                            r_loaded <= 1'b1;
                            r_state  <= StIdle;
                        end else begin
                            r_ncnt <= r_ncnt + 1'b1;
                        end
                    end
                end
                StFeed: begin
                    if (w_in_fire) begin
                        r_nrn_in_valid <= 1'b1;
                        r_nrn_in       <= io_bus.in_data;
                        if (w_clear) begin
                            r_wcnt  <= '0;
                            r_timer <= '0;
                            r_state <= StWait;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (w_mask_full) begin
                        r_state <= StDrain;
                    end else if (r_timer == T_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= StDrain;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StDrain: begin
                    if (w_drain_done) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    layer_sequencer_result_collector #(
        .NUM_NEURON (NUM_NEURON),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_collector (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_clear        (w_clear),
        .i_capture      (r_state == StWait),
        .i_drain        (r_state == StDrain),
        .i_nrn_outvalid (i_nrn_outvalid),
        .i_nrn_out      (i_nrn_out),
        .i_out_ready    (io_bus.out_ready),
        .o_out_valid    (io_bus.out_valid),
        .o_out_data     (io_bus.out_data),
        .o_out_last     (io_bus.out_last),
        .o_mask_full    (w_mask_full),
        .o_drain_done   (w_drain_done)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with 2 neurons of 4 weights and an 8-cycle wait timeout.
// Inputs change and outputs are sampled on the falling edge.
module tb_layer_sequencer;

    localparam int DW = 16;
    localparam int OW = 16;
    localparam int NW = 4;
    localparam int NN = 2;
    localparam int SW = 2 * DW + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            nrn_rst;
    logic            weight_valid;
    logic [DW-1:0]   weight_value;
    logic [NN-1:0]   bias_valid;
    logic [DW-1:0]   bias_value;
    logic [SW-1:0]   layer_num;
    logic [SW-1:0]   neuron_num;
    logic            nrn_in_valid;
    logic [DW-1:0]   nrn_in;
    logic [NN-1:0]   nrn_outvalid;
    logic [NN*OW-1:0] nrn_out;
    logic            loaded;
    logic            busy;
    logic            err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses;
    logic [5:0] pat;

    layer_sequencer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) u_bus ();

    layer_sequencer #(
        .DATA_WIDTH   (DW),
        .OUT_WIDTH    (OW),
        .NUM_WEIGHT   (NW),
        .NUM_NEURON   (NN),
        .LAYER_NO     (1),
        .WAIT_TIMEOUT (8)
    ) u_dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .io_bus              (u_bus),
        .o_nrn_rst           (nrn_rst),
        .o_weight_valid      (weight_valid),
        .o_weight_value      (weight_value),
        .o_bias_valid        (bias_valid),
        .o_bias_value        (bias_value),
        .o_config_layer_num  (layer_num),
        .o_config_neuron_num (neuron_num),
        .o_nrn_in_valid      (nrn_in_valid),
        .o_nrn_in            (nrn_in),
        .i_nrn_outvalid      (nrn_outvalid),
        .i_nrn_out           (nrn_out),
        .o_loaded            (loaded),
        .o_busy              (busy),
        .o_err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        u_bus.cfg_start    = 1'b0;
        u_bus.cfg_valid    = 1'b0;
        u_bus.cfg_data     = '0;
        u_bus.in_valid     = 1'b0;
        u_bus.in_data      = '0;
        u_bus.out_ready    = 1'b0;
        nrn_outvalid       = '0;
        nrn_out            = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_loaded", 64'(loaded), 64'd0);
        chk("rst_layer_num", 64'(layer_num), 64'd1);
        chk("rst_neuron_num", 64'(neuron_num), 64'd0);
        chk("rst_cfg_ready", 64'(u_bus.cfg_ready), 64'd0);
        chk("rst_in_ready", 64'(u_bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(u_bus.out_valid), 64'd0);
        chk("rst_nrn_rst", 64'(nrn_rst), 64'd0);
        chk("rst_weight_valid", 64'(weight_valid), 64'd0);
        chk("rst_bias_valid", 64'(bias_valid), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_nrn_in_valid", 64'(nrn_in_valid), 64'd0);
        rst_n = 1'b1;

        // Inference before any load is refused
        u_bus.in_valid = 1'b1;
        u_bus.in_data  = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noload_in_ready", 64'(u_bus.in_ready), 64'd0);
            chk("noload_busy", 64'(busy), 64'd0);
            chk("noload_nrn_in_valid", 64'(nrn_in_valid), 64'd0);
        end
        u_bus.in_valid = 1'b0;

        // Config load: weights 1..8, biases 9 and 10
        u_bus.cfg_start = 1'b1;
        tick();
        chk("clr_nrn_rst", 64'(nrn_rst), 64'd1);
        chk("clr_busy", 64'(busy), 64'd1);
        u_bus.cfg_start = 1'b0;
        tick();
        chk("loadw_nrn_rst_low", 64'(nrn_rst), 64'd0);
        chk("loadw_cfg_ready", 64'(u_bus.cfg_ready), 64'd1);
        chk("loadw_loaded", 64'(loaded), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            u_bus.cfg_valid = 1'b1;
            u_bus.cfg_data  = 16'(i);
            tick();
            chk("cfg_nrn_rst", 64'(nrn_rst), 64'd0);
            if (i <= 8) begin
                chk("w_valid", 64'(weight_valid), 64'd1);
                chk("w_value", 64'(weight_value), 64'(i));
                chk("w_neuron_num", 64'(neuron_num), 64'((i - 1) / 4));
                chk("w_bias_valid", 64'(bias_valid), 64'd0);
            end else begin
                chk("b_valid", 64'(bias_valid), 64'(1 << (i - 9)));
                chk("b_value", 64'(bias_value), 64'(i));
                chk("b_weight_valid", 64'(weight_valid), 64'd0);
                chk("b_neuron_num", 64'(neuron_num), 64'h1_FFFF_FFFF);
            end
        end
        u_bus.cfg_valid = 1'b0;
        chk("cfg_loaded", 64'(loaded), 64'd1);
        chk("cfg_idle", 64'(busy), 64'd0);
        chk("cfg_ready_idle", 64'(u_bus.cfg_ready), 64'd0);
        tick();
        chk("cfg_bias_pulse_end", 64'(bias_valid), 64'd0);

        // Inference with gaps: pattern 1 0 1 1 0 1
        u_bus.in_valid = 1'b1;
        u_bus.in_data  = 16'h0011;
        tick();
        chk("feed_busy", 64'(busy), 64'd1);
        chk("feed_in_ready", 64'(u_bus.in_ready), 64'd1);
        chk("feed_no_early_valid", 64'(nrn_in_valid), 64'd0);
        pat      = 6'b101101;
        n_pulses = 0;
        for (int j = 0; j < 6; j++) begin
            u_bus.in_valid = pat[j];
            u_bus.in_data  = 16'(16'h20 + j);
            tick();
            chk("feed_nrn_in_valid", 64'(nrn_in_valid), 64'(pat[j]));
            if (pat[j]) begin
                chk("feed_nrn_in", 64'(nrn_in), 64'(16'h20 + j));
            end
            if (nrn_in_valid) n_pulses++;
        end
        u_bus.in_valid = 1'b0;
        chk("feed_pulse_count", 64'(n_pulses), 64'd4);
        chk("wait_in_ready", 64'(u_bus.in_ready), 64'd0);

        // Staggered outvalid: neuron 1 first, neuron 0 three cycles later
        nrn_outvalid = 2'b10;
        nrn_out      = 32'h00AB_00CD;
        tick();
        nrn_outvalid = 2'b00;
        chk("wait_nrn_in_valid", 64'(nrn_in_valid), 64'd0);
        chk("wait_out_valid1", 64'(u_bus.out_valid), 64'd0);
        tick();
        tick();
        nrn_outvalid = 2'b01;
        tick();
        nrn_outvalid = 2'b00;
        nrn_out      = 32'hFFFF_FFFF;
        chk("wait_out_valid2", 64'(u_bus.out_valid), 64'd0);
        tick();
        chk("drain_valid", 64'(u_bus.out_valid), 64'd1);
        chk("drain_data0", 64'(u_bus.out_data), 64'h00CD);
        chk("drain_last0", 64'(u_bus.out_last), 64'd0);

        // Back-pressure holds index and data
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(u_bus.out_valid), 64'd1);
            chk("bp_data", 64'(u_bus.out_data), 64'h00CD);
            chk("bp_last", 64'(u_bus.out_last), 64'd0);
        end
        u_bus.out_ready = 1'b1;
        tick();
        chk("drain_valid1", 64'(u_bus.out_valid), 64'd1);
        chk("drain_data1", 64'(u_bus.out_data), 64'h00AB);
        chk("drain_last1", 64'(u_bus.out_last), 64'd1);
        tick();
        chk("drain_done_valid", 64'(u_bus.out_valid), 64'd0);
        chk("drain_done_idle", 64'(busy), 64'd0);
        u_bus.out_ready = 1'b0;

        // Timeout: neuron 1 never reports
        u_bus.in_valid = 1'b1;
        u_bus.in_data  = 16'h0030;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        u_bus.in_valid = 1'b0;
        nrn_outvalid   = 2'b01;
        nrn_out        = 32'hFFFF_0055;
        tick();
        nrn_outvalid = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk("to_err_early", 64'(err_timeout), 64'd0);
        chk("to_valid_early", 64'(u_bus.out_valid), 64'd0);
        tick();
        chk("to_err", 64'(err_timeout), 64'd1);
        chk("to_valid", 64'(u_bus.out_valid), 64'd1);
        chk("to_data0", 64'(u_bus.out_data), 64'h0055);
        u_bus.out_ready = 1'b1;
        tick();
        chk("to_data1_zero", 64'(u_bus.out_data), 64'd0);
        chk("to_last1", 64'(u_bus.out_last), 64'd1);
        tick();
        u_bus.out_ready = 1'b0;
        chk("to_valid_end", 64'(u_bus.out_valid), 64'd0);
        chk("to_err_sticky", 64'(err_timeout), 64'd1);
        u_bus.cfg_start = 1'b1;
        tick();
        u_bus.cfg_start = 1'b0;
        chk("to_err_cleared", 64'(err_timeout), 64'd0);
        chk("reload_nrn_rst", 64'(nrn_rst), 64'd1);

        // Asynchronous reset in the middle of the weight load
        tick();
        u_bus.cfg_valid = 1'b1;
        u_bus.cfg_data  = 16'h0101;
        tick();
        chk("mid_w_valid", 64'(weight_valid), 64'd1);
        u_bus.cfg_data = 16'h0102;
        tick();
        chk("mid_w_value", 64'(weight_value), 64'h0102);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_weight_valid", 64'(weight_valid), 64'd0);
        chk("arst_weight_value", 64'(weight_value), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cfg_ready", 64'(u_bus.cfg_ready), 64'd0);
        chk("arst_loaded", 64'(loaded), 64'd0);
        chk("arst_neuron_num", 64'(neuron_num), 64'd0);
        u_bus.cfg_valid = 1'b0;
        tick();
        rst_n          = 1'b1;
        u_bus.in_valid = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(u_bus.in_ready), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        tick();
        chk("post_rst_nrn_in_valid", 64'(nrn_in_valid), 64'd0);
        chk("post_rst_in_ready2", 64'(u_bus.in_ready), 64'd0);
        u_bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
